// File: rtl/mem_line_responder_pkg.sv
// Shared types for the 256-bit cache-line memory responder.
package mem_line_responder_pkg;

   localparam int MEM_LINE_BYTES  = 32;
   localparam int MEM_OFFSET_BITS = 5;
   localparam int MEM_LINE_WORDS  = MEM_LINE_BYTES / 4;

   typedef logic [MEM_LINE_WORDS-1:0][31:0] mem_line_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESPOND,
      RELEASE
   } mem_resp_state_e;

endpackage

// File: rtl/mem_line_responder_line_ram.sv
// Single-port line store: write wins over read, read data registered and held
// until the next read.
module line_ram
   import mem_line_responder_pkg::*;
#(
   parameter int LINES     = 256,
   parameter     INIT_FILE = "",
   localparam int IW       = $clog2(LINES)
) (
   input  logic          clock,
   input  logic          we,
   input  logic          re,
   input  logic [IW-1:0] addr,
   input  mem_line_t     wdata,
   output mem_line_t     rdata
);

   mem_line_t mem [LINES];

   always_ff @(posedge clock) begin
      if (we)
         mem[addr] <= wdata;
      else if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache-line bus: accepts one line read or write,
// answers LATENCY edges later with a single-cycle ready/done pulse.
module mem_line_responder
   import mem_line_responder_pkg::*;
#(
   parameter int LINES     = 256,
   parameter int LATENCY   = 4,
   parameter     INIT_FILE = ""
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_mem_read,
   input  logic         i_mem_write,
   input  logic [31:0]  i_mem_address,
   inout  wire  [255:0] io_mem_data,
   output logic         o_mem_ready,
   output logic         o_mem_done
);

   localparam int IW = $clog2(LINES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mem_resp_state_e state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            op_wr_q;
   logic [IW-1:0]   idx_q;
   mem_line_t       wdata_q;
   mem_line_t       rdata;

   logic            accept_wr, accept_rd, ram_we, ram_re;
   logic [IW-1:0]   in_idx, ram_addr;
   logic            unused_addr;

   assign in_idx      = i_mem_address[IW+MEM_OFFSET_BITS-1:MEM_OFFSET_BITS];
   assign unused_addr = ^{i_mem_address[31:IW+MEM_OFFSET_BITS], i_mem_address[MEM_OFFSET_BITS-1:0]};

   // Counter starts at LATENCY-1 and BUSY exits on zero, so BUSY always lasts
   // LATENCY cycles and the pulse lands LATENCY edges after acceptance.
   always_comb begin
      state_d   = state_q;
      accept_wr = 1'b0;
      accept_rd = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_mem_write) begin
               accept_wr = 1'b1;
               state_d   = BUSY;
            end else if (i_mem_read) begin
               accept_rd = 1'b1;
               ram_re    = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               ram_we  = op_wr_q;
               state_d = RESPOND;
            end
         end
         RESPOND: state_d = RELEASE;
         RELEASE: if (!i_mem_read && !i_mem_write) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept_wr || accept_rd) begin
            cnt_q   <= CW'(LATENCY - 1);
            op_wr_q <= accept_wr;
            idx_q   <= in_idx;
         end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (accept_wr)
            wdata_q <= io_mem_data;
      end
   end

   assign ram_addr = (state_q == IDLE) ? in_idx : idx_q;

   line_ram #(
      .LINES     (LINES),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (rdata)
   );

   // Outputs decode straight from state so an async reset drops them at once.
   assign o_mem_ready = (state_q == RESPOND) && !op_wr_q;
   assign o_mem_done  = (state_q == RESPOND) &&  op_wr_q;
   assign io_mem_data = o_mem_ready ? rdata : {256{1'bz}};

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench: one responder at LATENCY=4 and one at LATENCY=1.
module tb_mem_line_responder;

   localparam int LAT = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic         mem_rd, mem_wr, ready, done;
   logic [31:0]  mem_addr;
   logic [255:0] drv;
   logic         drv_en;
   wire  [255:0] bus;
   assign bus = drv_en ? drv : {256{1'bz}};

   logic         rd1, wr1, ready1, done1;
   logic [31:0]  addr1;
   logic [255:0] drv1;
   logic         drv1_en;
   wire  [255:0] bus1;
   assign bus1 = drv1_en ? drv1 : {256{1'bz}};

   mem_line_responder #(.LINES(256), .LATENCY(LAT), .INIT_FILE("")) u_dut (
      .clock         (clock),
      .reset         (reset),
      .i_mem_read    (mem_rd),
      .i_mem_write   (mem_wr),
      .i_mem_address (mem_addr),
      .io_mem_data   (bus),
      .o_mem_ready   (ready),
      .o_mem_done    (done)
   );

   mem_line_responder #(.LINES(256), .LATENCY(1), .INIT_FILE("")) u_dut1 (
      .clock         (clock),
      .reset         (reset),
      .i_mem_read    (rd1),
      .i_mem_write   (wr1),
      .i_mem_address (addr1),
      .io_mem_data   (bus1),
      .o_mem_ready   (ready1),
      .o_mem_done    (done1)
   );

   int tests = 0;
   int fails = 0;
   logic [255:0] line_a, line_b, line_c, line_d, line_e;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // An undriven net may resolve to z or to 0 depending on the tristate model.
   function automatic bit is_float(input logic [255:0] v);
      return (v === {256{1'bz}}) || (v === 256'd0);
   endfunction

   // One complete transaction on the LATENCY=4 responder; the address and
   // write data are scrambled after acceptance to prove they were captured.
   task automatic xact(input string tag, input bit w, input bit r_too,
                       input logic [31:0] a, input logic [255:0] wd,
                       input logic [255:0] exp_rd);
      int early;
      early    = 0;
      mem_wr   = w;
      mem_rd   = !w || r_too;
      mem_addr = a;
      drv      = wd;
      drv_en   = w;
      tick();
      mem_addr = 32'hFFFF_FFE0;
      drv      = ~wd;
      for (int k = 1; k < LAT; k++) begin
         tick();
         if (ready || done) early++;
         if (!w && !is_float(bus)) early++;
      end
      chk({tag, "/early"}, early, 0);
      tick();
      chk({tag, "/done"}, done, w);
      chk({tag, "/ready"}, ready, !w);
      if (!w) chk({tag, "/data"}, bus, exp_rd);
      mem_wr = 1'b0;
      mem_rd = 1'b0;
      drv_en = 1'b0;
      tick();
      chk({tag, "/pulse_end"}, {ready, done}, 2'b00);
      chk({tag, "/bus_z"}, is_float(bus), 1'b1);
      tick();
   endtask

   initial begin
      int n;
      reset = 1'b0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; drv = '0; drv_en = 1'b0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; drv1 = '0; drv1_en = 1'b0;
      line_a = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      line_b = {8{32'h0BAD_F00D}};
      line_c = {8{32'hC0DE_1234}};
      line_d = {8{32'hDEAD_BEEF}};
      line_e = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};

      #1;
      chk("rst/ready", ready, 1'b0);
      chk("rst/done", done, 1'b0);
      chk("rst/bus_z", is_float(bus), 1'b1);
      #11 reset = 1'b1;

      xact("wr40", 1'b1, 1'b0, 32'h0000_0040, line_a, '0);
      xact("rd40", 1'b0, 1'b0, 32'h0000_0040, '0, line_a);
      xact("rd205f", 1'b0, 1'b0, 32'h0000_205F, '0, line_a);

      // Both requests high: the write to 0x60 goes first, no ready pulse.
      xact("wr1000", 1'b1, 1'b0, 32'h0000_1000, line_b, '0);
      xact("both", 1'b1, 1'b1, 32'h0000_0060, line_c, '0);
      xact("rd1000", 1'b0, 1'b0, 32'h0000_1000, '0, line_b);
      xact("rd60", 1'b0, 1'b0, 32'h0000_0060, '0, line_c);

      // Held read must not be serviced twice.
      mem_rd = 1'b1; mem_addr = 32'h0000_0040;
      tick();
      repeat (LAT) tick();
      chk("held/ready", ready, 1'b1);
      n = 0;
      repeat (10) begin
         tick();
         if (ready || done) n++;
      end
      chk("held/no_repeat", n, 0);
      mem_rd = 1'b0;
      tick();
      tick();

      // Reset while driving read data.
      mem_rd = 1'b1; mem_addr = 32'h0000_0040;
      tick();
      repeat (LAT) tick();
      chk("rst_rd/ready_before", ready, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("rst_rd/ready", ready, 1'b0);
      chk("rst_rd/bus_z", is_float(bus), 1'b1);
      mem_rd = 1'b0;
      #2 reset = 1'b1;
      tick();

      // Reset mid-BUSY on a write: old line contents survive.
      mem_wr = 1'b1; mem_addr = 32'h0000_0040; drv = line_d; drv_en = 1'b1;
      tick();
      tick();
      tick();
      mem_wr = 1'b0; drv_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_wr/done", done, 1'b0);
      chk("rst_wr/ready", ready, 1'b0);
      chk("rst_wr/bus_z", is_float(bus), 1'b1);
      #2 reset = 1'b1;
      tick();
      xact("rd40_after_rst", 1'b0, 1'b0, 32'h0000_0040, '0, line_a);

      // LATENCY=1 responder.
      wr1 = 1'b1; addr1 = 32'h0000_0020; drv1 = line_e; drv1_en = 1'b1;
      tick();
      chk("l1/wr_accept_edge", done1, 1'b0);
      tick();
      chk("l1/done", done1, 1'b1);
      wr1 = 1'b0; drv1_en = 1'b0;
      tick();
      chk("l1/done_end", done1, 1'b0);
      tick();
      rd1 = 1'b1; addr1 = 32'h0000_0020;
      tick();
      chk("l1/rd_accept_edge", ready1, 1'b0);
      chk("l1/bus_z_before", is_float(bus1), 1'b1);
      tick();
      chk("l1/ready", ready1, 1'b1);
      chk("l1/data", bus1, line_e);
      rd1 = 1'b0;
      tick();
      chk("l1/ready_end", ready1, 1'b0);
      chk("l1/bus_z_after", is_float(bus1), 1'b1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
